// File: rtl/pxl_stream_tx.sv
// Frame-buffered raster pixel transmitter feeding the conv layer pxl_in.
// Optional continuous looping with PXL_TX_LOOP_EN.
module pxl_stream_tx #(
  parameter int PP    = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int AW    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic signed [PP:0] wr_data,
  input  logic               start,
  output logic signed [PP:0] pxl_out,
  output logic               pxl_valid,
  output logic               sof,
  output logic               eol,
  output logic               busy,
  output logic               done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [AW:0] DEPTH = (AW + 1)'(NPIX);
  localparam logic [AW-1:0] LAST_C = AW'(IMG_W - 1);
  localparam logic [AW-1:0] LAST_R = AW'(IMG_H - 1);

`ifdef PXL_TX_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } state_t;

  state_t state, nxt;

  logic signed [PP:0] mem [NPIX];
  logic signed [PP:0] rdata;

  logic [AW-1:0] row, col, addr;
  logic          issue;
  logic          at_end;
  logic          wr_ok;

  logic rv, rsof, reol, rlast;
  logic last_o;

  assign at_end = (row == LAST_R) && (col == LAST_C);
  assign wr_ok  = wr_en && (state == IDLE)
               && ({1'b0, wr_addr} < DEPTH);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state; a read is issued every FETCH/STREAM cycle
  always_comb begin
    nxt   = state;
    issue = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = FETCH;
      end
      FETCH, STREAM: begin
        issue = 1'b1;
        if (at_end) nxt = (LOOP && start) ? STREAM : IDLE;
        else        nxt = STREAM;
      end
      default: nxt = IDLE;
    endcase
  end

  // Raster counters track the address being read this cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (issue) begin
      if (col == LAST_C) begin
        col <= '0;
        row <= (row == LAST_R) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      addr <= at_end ? '0 : addr + 1'b1;
    end
  end

  // Frame buffer: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    rdata <= mem[addr];
  end

  // Markers travelling alongside the RAM read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv    <= 1'b0;
      rsof  <= 1'b0;
      reol  <= 1'b0;
      rlast <= 1'b0;
    end else begin
      rv    <= issue;
      rsof  <= issue && (addr == '0);
      reol  <= issue && (col == LAST_C);
      rlast <= issue && at_end;
    end
  end

  // Registered pixel outputs; done follows the last pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pxl_out   <= '0;
      pxl_valid <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      last_o    <= 1'b0;
      done      <= 1'b0;
    end else begin
      pxl_out   <= rv ? rdata : '0;
      pxl_valid <= rv;
      sof       <= rsof;
      eol       <= reol;
      last_o    <= rlast;
      done      <= last_o;
    end
  end

  assign busy = (state != IDLE) || rv || pxl_valid;

endmodule

// File: tb/tb_pxl_stream_tx.sv
// Randomized bench for pxl_stream_tx against a frame-level model.
// Covers a 32x32 and a 5x3 instance; honours PXL_TX_LOOP_EN.
module tb_pxl_stream_tx;

`ifdef PXL_TX_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              start_m = 0, wen_m = 0;
  logic [9:0]        waddr_m = '0;
  logic signed [8:0] wdat_m = '0;
  logic signed [8:0] pxl_m;
  logic vld_m, sof_m, eol_m, busy_m, done_m;

  logic              start_s = 0, wen_s = 0;
  logic [3:0]        waddr_s = '0;
  logic signed [8:0] wdat_s = '0;
  logic signed [8:0] pxl_s;
  logic vld_s, sof_s, eol_s, busy_s, done_s;

  logic [8:0] img_m [1024];
  logic [8:0] img_s [16];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pxl_stream_tx #(.PP(8), .IMG_W(32), .IMG_H(32), .AW(10)) dut (
    .clk(clk), .reset(rst),
    .wr_en(wen_m), .wr_addr(waddr_m), .wr_data(wdat_m),
    .start(start_m),
    .pxl_out(pxl_m), .pxl_valid(vld_m), .sof(sof_m),
    .eol(eol_m), .busy(busy_m), .done(done_m)
  );

  pxl_stream_tx #(.PP(8), .IMG_W(5), .IMG_H(3), .AW(4)) dut_s (
    .clk(clk), .reset(rst),
    .wr_en(wen_s), .wr_addr(waddr_s), .wr_data(wdat_s),
    .start(start_s),
    .pxl_out(pxl_s), .pxl_valid(vld_s), .sof(sof_s),
    .eol(eol_s), .busy(busy_s), .done(done_s)
  );

  function automatic logic [15:0] obs(input bit s);
    if (s)
      return {2'b0, busy_s, done_s, sof_s, eol_s, vld_s, pxl_s};
    return {2'b0, busy_m, done_m, sof_m, eol_m, vld_m, pxl_m};
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected {busy,done,sof,eol,valid,pixel} t cycles after start edge
  function automatic logic [15:0] expv(input bit s, input int t,
                                       input int nfr, input bit lp);
    int n, w, tend, o;
    logic v, sf, el, dn, bz;
    logic [8:0] px;
    n = s ? 15 : 1024;
    w = s ? 5 : 32;
    tend = lp ? 2 + nfr * n : 2 + n + (nfr - 1) * (n + 1);
    v = 0; sf = 0; el = 0; dn = 0; px = '0;
    bz = (t < tend);
    if (t >= 2 && t < tend) begin
      o = lp ? (t - 2) % n : (t - 2) % (n + 1);
      if (o < n) begin
        v  = 1;
        sf = (o == 0);
        el = (o % w) == (w - 1);
        px = s ? img_s[o] : img_m[o];
      end
      dn = lp ? (t > 2 && o == 0) : (o == n);
    end
    if (t == tend) dn = 1;
    return {2'b0, bz, dn, sf, el, v, px};
  endfunction

  task automatic wr(input bit s, input int a, input logic [8:0] d);
    if (s) begin
      wen_s = 1; waddr_s = a[3:0]; wdat_s = d;
      if (a < 15) img_s[a] = d;
    end else begin
      wen_m = 1; waddr_m = a[9:0]; wdat_m = d;
      if (a < 1024) img_m[a] = d;
    end
    @(negedge clk);
    wen_s = 0;
    wen_m = 0;
  endtask

  // Start, then compare every cycle to the model; optional
  // ignored write of 0x0FF to addr 5 at cycle wr_t
  task automatic run(input bit s, input int nfr,
                     input bit lp, input int wr_t);
    int n, tend, tdrop;
    n = s ? 15 : 1024;
    tend = lp ? 2 + nfr * n : 2 + n + (nfr - 1) * (n + 1);
    tdrop = lp ? 2 + (nfr - 1) * n + n / 2 : (nfr - 1) * (n + 1);
    if (s) start_s = 1; else start_m = 1;
    @(negedge clk);
    for (int t = 0; t <= tend + 1; t++) begin
      chk(s ? "stream_s" : "stream_m", obs(s), expv(s, t, nfr, lp));
      if (t == tdrop) begin
        start_s = 0;
        start_m = 0;
      end
      if (t == wr_t) begin
        wen_m = 1; waddr_m = 10'd5; wdat_m = 9'h0FF;
      end else begin
        wen_m = 0;
      end
      @(negedge clk);
    end
    wen_m = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int v;
    repeat (3) @(negedge clk);
    chk("in_reset", obs(0), 16'h0);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_m", obs(0), 16'h0);
      chk("idle_s", obs(1), 16'h0);
    end

    for (int i = 0; i < 1024; i++) begin
      v = (i % 256) - 128;
      wr(0, i, 9'(v));
    end
    run(0, 1, 0, -1);

    run(0, 1, 0, 300);
    chk("addr5_kept", {7'b0, img_m[5]}, 16'h185);
    run(0, 1, 0, -1);

    if (LOOP) run(0, 3, 1, -1);
    else      run(0, 2, 0, -1);

    for (int i = 0; i < 200; i++)
      wr(0, $urandom_range(1023), 9'($urandom));
    run(0, 1, 0, -1);

    for (int i = 0; i < 15; i++)
      wr(1, i, 9'($urandom));
    wr(1, 15, 9'h0AA);
    run(1, 1, 0, -1);
    if (LOOP) run(1, 2, 1, -1);
    else      run(1, 3, 0, -1);

    start_m = 1;
    @(negedge clk);
    start_m = 0;
    repeat (102) @(negedge clk);
    chk("pix100", obs(0), expv(0, 102, 1, 0));
    rst = 1;
    #1;
    chk("rst_async", obs(0), 16'h0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 1030; i++) begin
      @(negedge clk);
      if (i < 10 || done_m) chk("post_rst", obs(0), 16'h0);
    end
    run(0, 1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
